sha256d_block_sequencer: RTL and testbench

- Sequences the shared SHA-256 compression datapath through the three blocks of a Bitcoin double hash: header chunk 0, header chunk 1 plus padding, then the 256-bit first digest plus padding.
- Drives the 2-bit block-phase code consumed by the H1..H8 chaining registers, the round counter and the message-source select.
- Iterates the nonce over a range until the external target compare hits or the range is exhausted.

---
 rtl/sha256_pkg.sv | 48 ++++
 rtl/sha256_round_counter.sv | 39 +++
 rtl/sha256d_block_sequencer.sv | 174 +++++++++++++++++
 tb/tb_sha256d_block_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256d block sequencer and compression core.
// Contents: sequencer state enum, message-source select codes, block-phase
// codes for the H1..H8 chaining registers, default round count and decode
// helpers that map a sequencer state to its phase / message source.
package sha256_pkg;

    localparam int unsigned ROUNDS_DEFAULT = 64;

    // W message source select
    localparam logic [1:0] MSG_HDR0   = 2'd0;  // header[511:0]
    localparam logic [1:0] MSG_HDR1   = 2'd1;  // header tail + padding
    localparam logic [1:0] MSG_DIGEST = 2'd2;  // first digest + padding

    // Block-phase code seen by the chaining registers
    localparam logic [1:0] HBLK_INIT = 2'd0;
    localparam logic [1:0] HBLK_1    = 2'd1;
    localparam logic [1:0] HBLK_2    = 2'd2;
    localparam logic [1:0] HBLK_3    = 2'd3;

    typedef enum logic [3:0] {
        StIdle,
        StInit1, StRnd1, StFin1,
        StInit2, StRnd2, StFin2,
        StInit3, StRnd3, StFin3,
        StCheck
    } seq_state_e;

    // Phase code belonging to a state; hblock is registered from the next
    // state so it changes exactly once, on the cycle after each FINk.
    function automatic logic [1:0] hblk_of(seq_state_e s);
        case (s)
            StInit2, StRnd2, StFin2: hblk_of = HBLK_1;
            StInit3, StRnd3, StFin3: hblk_of = HBLK_2;
            StCheck:                 hblk_of = HBLK_3;
            default:                 hblk_of = HBLK_INIT;
        endcase
    endfunction

    // Message source for a state; the digest source is held through CHECK.
    function automatic logic [1:0] msg_of(seq_state_e s);
        case (s)
            StInit2, StRnd2, StFin2:          msg_of = MSG_HDR1;
            StInit3, StRnd3, StFin3, StCheck: msg_of = MSG_DIGEST;
            default:                          msg_of = MSG_HDR0;
        endcase
    endfunction

endpackage

// File: rtl/sha256_round_counter.sv
// Compression round counter: clears on load, increments on en, flags the
// last round. Load has priority over enable.
// Ports: clk, rst_n (async active-low), load (clear to 0), en (count up),
//        count (current round), tc (count == LAST).
module sha256_round_counter #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned LAST  = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == WIDTH'(LAST));

endmodule

// File: rtl/sha256d_block_sequencer.sv
// Sequences the shared SHA-256 compression datapath through the three blocks
// of a Bitcoin double hash (header chunk 0, header chunk 1 + pad, digest + pad)
// and iterates the nonce over [nonce_start, nonce_end] until target_hit or the
// range is exhausted / stop is seen at an attempt boundary.
// Ports: clk, rst_n (async active-low); start (pulse), stop (level),
//        nonce_start/nonce_end (sampled on accepted start), target_hit (valid
//        in CHECK); busy, done (pulse), found, nonce; hblock (phase code),
//        msg_sel (W source), core_init, round_en, round, h_capture.
module sha256d_block_sequencer
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS  = ROUNDS_DEFAULT,
    parameter int unsigned NONCE_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    input  logic               target_hit,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [NONCE_W-1:0] nonce,
    output logic [1:0]         hblock,
    output logic [1:0]         msg_sel,
    output logic               core_init,
    output logic               round_en,
    output logic [5:0]         round,
    output logic               h_capture
);

    seq_state_e state_q, state_d;

    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [NONCE_W-1:0] nonce_end_q, nonce_end_d;
    logic               found_q, found_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         hblock_q, hblock_d;
    logic [1:0]         msg_sel_q, msg_sel_d;

    logic start_ok;
    logic last_nonce;
    logic cnt_load;
    logic cnt_en;
    logic round_tc;

    // done_q is high only in the first IDLE cycle; a start there is dropped.
    assign start_ok   = start && !busy_q && !done_q;
    assign last_nonce = (nonce_q == nonce_end_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok) state_d = StInit1;
            StInit1: state_d = StRnd1;
            StRnd1:  if (round_tc) state_d = StFin1;
            StFin1:  state_d = StInit2;
            StInit2: state_d = StRnd2;
            StRnd2:  if (round_tc) state_d = StFin2;
            StFin2:  state_d = StInit3;
            StInit3: state_d = StRnd3;
            StRnd3:  if (round_tc) state_d = StFin3;
            StFin3:  state_d = StCheck;
            StCheck: begin
                if (target_hit || last_nonce || stop) begin
                    state_d = StIdle;
                end else begin
                    state_d = StInit1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Per-state strobes to the compression core
    always_comb begin
        core_init = 1'b0;
        round_en  = 1'b0;
        h_capture = 1'b0;
        unique case (state_q)
            StInit1, StInit2, StInit3: core_init = 1'b1;
            StRnd1, StRnd2, StRnd3:    round_en  = 1'b1;
            StFin1, StFin2, StFin3:    h_capture = 1'b1;
            default: ;
        endcase
    end

    // Round counter is cleared on entry to INITk (and while idle) so it reads
    // 0 in INITk and the first RNDk cycle; it holds ROUNDS-1 through FINk.
    assign cnt_load = (state_d == StIdle) || (state_d == StInit1) ||
                      (state_d == StInit2) || (state_d == StInit3);
    assign cnt_en   = round_en && !round_tc;

    sha256_round_counter #(
        .WIDTH (6),
        .LAST  (ROUNDS - 1)
    ) u_round_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .en    (cnt_en),
        .count (round),
        .tc    (round_tc)
    );

    // Search bookkeeping
    always_comb begin
        nonce_d     = nonce_q;
        nonce_end_d = nonce_end_q;
        found_d     = found_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        hblock_d    = hblk_of(state_d);
        msg_sel_d   = msg_of(state_d);

        if (state_q == StIdle && start_ok) begin
            nonce_d     = nonce_start;
            nonce_end_d = nonce_end;
            found_d     = 1'b0;
            busy_d      = 1'b1;
        end

        if (state_q == StCheck) begin
            if (state_d == StIdle) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                found_d = target_hit;
            end else begin
                nonce_d = nonce_q + NONCE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_q     <= '0;
            nonce_end_q <= '0;
            found_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hblock_q    <= HBLK_INIT;
            msg_sel_q   <= MSG_HDR0;
        end else begin
            nonce_q     <= nonce_d;
            nonce_end_q <= nonce_end_d;
            found_q     <= found_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            hblock_q    <= hblock_d;
            msg_sel_q   <= msg_sel_d;
        end
    end

    assign nonce   = nonce_q;
    assign found   = found_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign hblock  = hblock_q;
    assign msg_sel = msg_sel_q;

endmodule

// File: tb/tb_sha256d_block_sequencer.sv
// Self-checking bench for sha256d_block_sequencer: directed range/hit/stop/
// wrap/reset scenarios plus randomized searches, checked against a nonce-level
// reference model and a per-cycle block/round protocol monitor.
module tb_sha256d_block_sequencer;

    localparam int unsigned ROUNDS  = 64;
    localparam int unsigned NONCE_W = 32;
    localparam int unsigned ATT_LAT = 3 * (ROUNDS + 2) + 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [NONCE_W-1:0] nonce_start = '0;
    logic [NONCE_W-1:0] nonce_end = '0;
    logic               target_hit;
    logic               busy, done, found;
    logic [NONCE_W-1:0] nonce;
    logic [1:0]         hblock, msg_sel;
    logic               core_init, round_en, h_capture;
    logic [5:0]         round;

    logic               hit_en = 1'b0;
    logic [NONCE_W-1:0] hit_nonce = '0;

    // Environment: the digest matches the target only for hit_nonce.
    assign target_hit = hit_en && (hblock == 2'd3) && (nonce == hit_nonce);

    sha256d_block_sequencer #(
        .ROUNDS  (ROUNDS),
        .NONCE_W (NONCE_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .target_hit  (target_hit),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .nonce       (nonce),
        .hblock      (hblock),
        .msg_sel     (msg_sel),
        .core_init   (core_init),
        .round_en    (round_en),
        .round       (round),
        .h_capture   (h_capture)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Protocol monitor: block index is derived from the count of core_init
    // pulses, independently of the DUT phase outputs.
    int                 n_init = 0;
    int                 n_cap = 0;
    int                 n_ren = 0;
    int                 rcount = 0;
    int                 blk = 0;
    logic [NONCE_W-1:0] tested[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (core_init) begin
                blk = n_init % 3;
                n_init++;
                rcount = 0;
                check_eq("init_round", 64'(round), 64'd0);
                check_eq("init_hblock", 64'(hblock), 64'(blk));
                check_eq("init_msg_sel", 64'(msg_sel), 64'(blk));
            end
            if (round_en) begin
                n_ren++;
                check_eq("rnd_index", 64'(round), 64'(rcount));
                check_eq("rnd_hblock", 64'(hblock), 64'(blk));
                check_eq("rnd_msg_sel", 64'(msg_sel), 64'(blk));
                rcount++;
            end
            if (h_capture) begin
                n_cap++;
                check_eq("fin_round_cycles", 64'(rcount), 64'(ROUNDS));
                check_eq("fin_hblock", 64'(hblock), 64'(blk));
            end
            if (busy && !core_init && !round_en && !h_capture) begin
                check_eq("check_hblock", 64'(hblock), 64'd3);
                check_eq("check_after_blk3", 64'(blk), 64'd2);
                tested.push_back(nonce);
            end
        end
    end

    task automatic clear_mon();
        n_init = 0;
        n_cap  = 0;
        n_ren  = 0;
        rcount = 0;
        blk    = 0;
        tested.delete();
    endtask

    // One search: model computes the nonce sequence and outcome from the
    // range / hit / stop rules, then the DUT run is compared against it.
    task automatic run_search(input logic [NONCE_W-1:0] ns, input logic [NONCE_W-1:0] ne,
                              input logic hen, input logic [NONCE_W-1:0] hn,
                              input int stop_att, input logic poke_busy,
                              input logic start_at_done);
        logic [NONCE_W-1:0] exp_q[$];
        logic [NONCE_W-1:0] n;
        logic               exp_found;
        int                 att;
        int                 k;
        int                 budget;

        n         = ns;
        att       = 0;
        exp_found = 1'b0;
        while (att < 1000) begin
            exp_q.push_back(n);
            att++;
            if (hen && n == hn) begin
                exp_found = 1'b1;
                break;
            end
            if (n == ne) break;
            if (stop_att > 0 && att >= stop_att) break;
            n = n + 1'b1;
        end

        clear_mon();
        nonce_start = ns;
        nonce_end   = ne;
        hit_en      = hen;
        hit_nonce   = hn;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k      = 0;
        budget = att * ATT_LAT + 20;
        while (!done && k < budget) begin
            @(posedge clk); #1;
            k++;
            if (stop_att > 0 && n_init >= 3 * (stop_att - 1) + 1) stop = 1'b1;
            if (poke_busy && k == 100) begin
                start       = 1'b1;
                nonce_start = ns + 32'd7;
                nonce_end   = ns + 32'd7;
            end else begin
                start = 1'b0;
            end
        end
        check_eq("done_seen", 64'(done), 64'd1);
        check_eq("latency", 64'(k), 64'(att * ATT_LAT));
        check_eq("found", 64'(found), 64'(exp_found));
        check_eq("final_nonce", 64'(nonce), 64'(exp_q[exp_q.size() - 1]));
        check_eq("busy_at_done", 64'(busy), 64'd0);
        check_eq("core_init_count", 64'(n_init), 64'(3 * att));
        check_eq("h_capture_count", 64'(n_cap), 64'(3 * att));
        check_eq("round_en_count", 64'(n_ren), 64'(3 * att * ROUNDS));
        check_eq("attempt_count", 64'(tested.size()), 64'(att));
        for (int i = 0; i < att && i < tested.size(); i++) begin
            check_eq($sformatf("nonce_seq[%0d]", i), 64'(tested[i]), 64'(exp_q[i]));
        end
        stop = 1'b0;
        if (start_at_done) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check_eq("done_one_cycle", 64'(done), 64'd0);
        check_eq("idle_after_done", 64'(busy), 64'd0);
        check_eq("found_held", 64'(found), 64'(exp_found));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NONCE_W-1:0] rs, re, rh;
        int                 len;
        int                 k;

        // Reset state
        #2;
        check_eq("rst_hblock", 64'(hblock), 64'd0);
        check_eq("rst_msg_sel", 64'(msg_sel), 64'd0);
        check_eq("rst_round", 64'(round), 64'd0);
        check_eq("rst_nonce", 64'(nonce), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_found", 64'(found), 64'd0);
        check_eq("rst_strobes", 64'({core_init, round_en, h_capture}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single attempt; start coinciding with done must be ignored
        run_search(32'h0000_1000, 32'h0000_1000, 1'b0, 32'h0, 0, 1'b0, 1'b1);
        // Two attempts, hit on the second; start while busy ignored
        run_search(32'h10, 32'h12, 1'b1, 32'h11, 0, 1'b1, 1'b0);
        // Wrap through all-ones to zero
        run_search(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        // stop raised during RND1 of the second attempt
        run_search(32'h0, 32'hFF, 1'b0, 32'h0, 2, 1'b0, 1'b0);

        // Asynchronous reset in the middle of block 2
        clear_mon();
        nonce_start = 32'h5;
        nonce_end   = 32'h9;
        hit_en      = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        while (!(n_init == 2 && rcount >= 10) && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("reached_rnd2", 64'(n_init), 64'd2);
        @(negedge clk); #1 rst_n = 1'b0;
        #1;
        check_eq("arst_hblock", 64'(hblock), 64'd0);
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_round", 64'(round), 64'd0);
        check_eq("arst_nonce", 64'(nonce), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_mon();
        repeat (30) @(posedge clk);
        #1;
        check_eq("post_rst_h_capture", 64'(n_cap), 64'd0);
        check_eq("post_rst_core_init", 64'(n_init), 64'd0);
        check_eq("post_rst_busy", 64'(busy), 64'd0);
        check_eq("post_rst_hblock", 64'(hblock), 64'd0);

        // Randomized short searches
        for (int t = 0; t < 8; t++) begin
            rs  = $urandom;
            len = $urandom_range(0, 3);
            re  = rs + NONCE_W'(len);
            rh  = rs + NONCE_W'($urandom_range(0, len));
            run_search(rs, re, 1'($urandom_range(0, 1)), rh, $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute safety net against a hung DUT
    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
